// File: rtl/sprite_fetch_arbiter.sv
// Round-robin arbiter sharing one spritesheet RAM read port between drawers.
// Ports: Clk/Reset, req/req_addr in, ack out, ram_read_addr/ram_data, pix_* stream, busy.
module sprite_fetch_arbiter #(
   parameter int NUM_REQ = 5,
   parameter int ADDR_W  = 19,
   parameter int DATA_W  = 5,
   parameter int TILE_W  = 16,
   localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
   localparam int CW  = $clog2(TILE_W)
) (
   input  logic                      Clk,
   input  logic                      Reset,
   input  logic [NUM_REQ-1:0]        req,
   input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
   output logic [NUM_REQ-1:0]        ack,
   output logic [ADDR_W-1:0]         ram_read_addr,
   input  logic [DATA_W-1:0]         ram_data,
   output logic                      pix_valid,
   output logic [DATA_W-1:0]         pix_data,
   output logic [CW-1:0]             pix_col,
   output logic [IDW-1:0]            pix_id,
   output logic                      busy
);

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      DRAIN,
      DONE
   } state_t;

   state_t         state, state_nx;
   logic [IDW-1:0] rr_ptr;
   logic [IDW-1:0] gnt_id;
   logic [IDW-1:0] pick;
   logic [IDW-1:0] rr_nx;
   logic           found;
   logic [CW-1:0]  col_cnt;
   logic           last_col;

   assign last_col = (col_cnt == CW'(TILE_W - 1));
   assign rr_nx    = (gnt_id == IDW'(NUM_REQ - 1)) ? '0 : gnt_id + IDW'(1);

   // Scan from rr_ptr upward, wrapping at NUM_REQ; first set bit wins.
   always_comb begin
      logic [IDW:0]   sum;
      logic [IDW-1:0] cand;
      found = 1'b0;
      pick  = '0;
      sum   = '0;
      cand  = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         sum = {1'b0, rr_ptr} + (IDW+1)'(k);
         if (sum >= (IDW+1)'(NUM_REQ)) begin
            sum = sum - (IDW+1)'(NUM_REQ);
         end
         cand = sum[IDW-1:0];
         if (!found && req[cand]) begin
            found = 1'b1;
            pick  = cand;
         end
      end
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx = state;
      ack      = '0;
      busy     = (state != IDLE);
      unique case (state)
         IDLE:    if (found) state_nx = ISSUE;
         ISSUE:   if (last_col) state_nx = DRAIN;
         DRAIN:   state_nx = DONE;
         DONE: begin
            ack[gnt_id] = 1'b1;
            state_nx    = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   // The read address register doubles as base + col_cnt: it is loaded with
   // the base on grant and stepped every ISSUE cycle except the last, so it
   // holds the final address once the burst has been issued.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         rr_ptr        <= '0;
         gnt_id        <= '0;
         col_cnt       <= '0;
         ram_read_addr <= '0;
         pix_valid     <= 1'b0;
         pix_col       <= '0;
      end else begin
         pix_valid <= (state == ISSUE);
         if (state == ISSUE) begin
            pix_col <= col_cnt;
         end
         unique case (state)
            IDLE: begin
               if (found) begin
                  gnt_id        <= pick;
                  ram_read_addr <= req_addr[int'(pick)*ADDR_W +: ADDR_W];
                  col_cnt       <= '0;
               end
            end
            ISSUE: begin
               col_cnt <= col_cnt + CW'(1);
               if (!last_col) begin
                  ram_read_addr <= ram_read_addr + ADDR_W'(1);
               end
            end
            DONE:    rr_ptr <= rr_nx;
            default: ;
         endcase
      end
   end

   // RAM output is registered, so data for the previous cycle's address
   // arrives exactly when pix_valid/pix_col describe it.
   assign pix_data = pix_valid ? ram_data : '0;
   assign pix_id   = gnt_id;

endmodule

// File: tb/tb_sprite_fetch_arbiter.sv
// Testbench for sprite_fetch_arbiter: directed vectors, corner sequences and
// randomized traffic checked cycle by cycle against a burst-level model.
module tb_sprite_fetch_arbiter;

   localparam int N  = 5;
   localparam int AW = 19;
   localparam int DW = 5;
   localparam int TW = 16;

   logic            clk;
   logic            reset;
   logic [N-1:0]    req;
   logic [N*AW-1:0] req_addr;
   logic [N-1:0]    ack;
   logic [AW-1:0]   ram_read_addr;
   logic [DW-1:0]   ram_data;
   logic            pix_valid;
   logic [DW-1:0]   pix_data;
   logic [3:0]      pix_col;
   logic [2:0]      pix_id;
   logic            busy;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;
   bit chk_en   = 0;

   sprite_fetch_arbiter #(
      .NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .TILE_W(TW)
   ) dut (
      .Clk(clk), .Reset(reset), .req(req), .req_addr(req_addr),
      .ack(ack), .ram_read_addr(ram_read_addr), .ram_data(ram_data),
      .pix_valid(pix_valid), .pix_data(pix_data), .pix_col(pix_col),
      .pix_id(pix_id), .busy(busy)
   );

   initial clk = 0;
   always #5 clk = ~clk;

   // RAM with one-cycle registered read; mem[a] = a[4:0]
   always_ff @(posedge clk) ram_data <= ram_read_addr[4:0];

   initial forever begin
      @(posedge clk);
      cyc = cyc + 1;
   end

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks = checks + 1;
      if (act !== exp) begin
         failures = failures + 1;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                  nm, act, exp, cyc);
      end
   endtask

   function automatic int arb(input logic [N-1:0] r, input int p);
      for (int k = 0; k < N; k++) begin
         if (r[(p + k) % N]) return (p + k) % N;
      end
      return -1;
   endfunction

   function automatic logic [AW-1:0] slot(input logic [N*AW-1:0] a,
                                          input int i);
      return a[i*AW +: AW];
   endfunction

   task automatic set_addr(input int i, input logic [AW-1:0] a);
      req_addr[i*AW +: AW] = a;
   endtask

   // Burst-level model: ph = cycles since grant (-1 when idle).
   // Addresses at ph 0..TW-1, pixels at ph 1..TW, ack at ph TW+1.
   int            ph    = -1;
   int            mid   = 0;
   int            mptr  = 0;
   logic [AW-1:0] mbase = '0;
   logic [AW-1:0] maddr = '0;

   initial forever begin
      @(posedge clk);
      if (reset) begin
         ph = -1; mid = 0; mptr = 0; maddr = '0;
      end else if (ph < 0) begin
         if (req != 0) begin
            mid   = arb(req, mptr);
            mbase = slot(req_addr, mid);
            ph    = 0;
            maddr = mbase;
         end
      end else if (ph == TW + 1) begin
         ph   = -1;
         mptr = (mid + 1) % N;
      end else begin
         ph = ph + 1;
         if (ph < TW) maddr = mbase + AW'(ph);
      end
   end

   initial forever begin
      logic [AW-1:0] pa;
      @(negedge clk);
      if (chk_en) begin
         chk("m_busy", busy, 32'(ph >= 0));
         chk("m_addr", ram_read_addr, maddr);
         chk("m_valid", pix_valid, 32'(ph >= 1 && ph <= TW));
         chk("m_ack", ack, (ph == TW + 1) ? (32'd1 << mid) : 32'd0);
         chk("m_id", pix_id, mid);
         if (ph >= 1 && ph <= TW) begin
            pa = mbase + AW'(ph - 1);
            chk("m_col", pix_col, ph - 1);
            chk("m_data", pix_data, pa[4:0]);
         end
      end
   end

   task automatic wait_burst(input int t, input int id,
                             input logic [AW-1:0] base);
      int np = 0;
      bit got = 0;
      logic [AW-1:0] e;
      for (int k = 0; k < 60; k++) begin
         @(negedge clk);
         if (pix_valid) begin
            e = base + AW'(np);
            chk("pix_col", pix_col, np);
            chk("pix_data", pix_data, e[4:0]);
            np++;
         end
         if (ack != 0) begin
            got = 1;
            break;
         end
      end
      chk("ack_vec", ack, 32'd1 << id);
      if (got) chk("ack_lat", cyc - t, TW + 1);
      chk("npix", np, TW);
   endtask

   task automatic burst(input logic [N-1:0] m, input int id);
      int t;
      req = m;
      t = cyc + 1;
      wait_burst(t, id, slot(req_addr, id));
      req = '0;
      @(negedge clk);
   endtask

   task automatic do_reset();
      reset = 1;
      @(negedge clk);
      @(negedge clk);
      reset = 0;
   endtask

   task automatic wait_ack(output int id, output int at);
      id = -1;
      at = 0;
      for (int k = 0; k < 60; k++) begin
         @(negedge clk);
         if (ack != 0) break;
      end
      for (int i = 0; i < N; i++) if (ack[i]) id = i;
      at = cyc;
      if (ack == 0) chk("ack_timeout", ack, 32'h1);
   endtask

   typedef struct {
      logic [N-1:0] r;
      int           id;
   } vec_t;

   vec_t tbl[9];

   initial begin
      int ids[6];
      int ats[6];
      int id, at, t, np;
      logic [AW-1:0] a[TW];
      logic [AW-1:0] nb;

      tbl[0] = '{5'b11111, 1};
      tbl[1] = '{5'b00011, 0};
      tbl[2] = '{5'b00011, 1};
      tbl[3] = '{5'b10000, 4};
      tbl[4] = '{5'b11000, 3};
      tbl[5] = '{5'b11000, 4};
      tbl[6] = '{5'b00110, 1};
      tbl[7] = '{5'b00110, 2};
      tbl[8] = '{5'b00001, 0};

      req = '0;
      req_addr = '0;
      for (int i = 0; i < N; i++) set_addr(i, AW'(19'h100 + 19'h2040 * i));
      reset = 1;
      @(negedge clk);
      @(negedge clk);
      chk("rst_busy", busy, 0);
      chk("rst_ack", ack, 0);
      chk("rst_valid", pix_valid, 0);
      chk("rst_data", pix_data, 0);
      chk("rst_col", pix_col, 0);
      chk("rst_id", pix_id, 0);
      chk("rst_addr", ram_read_addr, 0);
      reset = 0;
      chk_en = 1;

      // single request, base 0x100
      burst(5'b00001, 0);

      // arbitration vectors, pointer carried from the previous grant
      for (int i = 0; i < 9; i++) burst(tbl[i].r, tbl[i].id);

      // all requesters held: order 0,1,2,3,4,0 at fixed period
      do_reset();
      req = 5'b11111;
      for (int i = 0; i < 6; i++) begin
         wait_ack(ids[i], ats[i]);
      end
      req = '0;
      @(negedge clk);
      for (int i = 0; i < 6; i++) chk("rr_order", ids[i], i % N);
      for (int i = 1; i < 6; i++) chk("rr_period", ats[i] - ats[i-1], TW + 3);

      // address wrap at top of RAM
      set_addr(3, 19'h7FFF8);
      req = 5'b01000;
      for (int i = 0; i < TW; i++) begin
         @(negedge clk);
         a[i] = ram_read_addr;
      end
      chk("wrap_a7", a[7], 19'h7FFFF);
      chk("wrap_a8", a[8], 19'h00000);
      chk("wrap_a15", a[15], 19'h00007);
      wait_ack(id, at);
      chk("wrap_id", id, 3);
      req = '0;
      @(negedge clk);

      // late request from 4 while 0 is being served
      req = 5'b00001;
      repeat (3) @(negedge clk);
      req = 5'b10001;
      wait_ack(id, at);
      chk("late_first", id, 0);
      t = at;
      req = 5'b10000;
      wait_ack(id, at);
      chk("late_second", id, 4);
      chk("late_gap", at - t, TW + 3);
      req = '0;
      @(negedge clk);

      // reset at the 5th pixel, held request re-granted in full
      req = 5'b00100;
      np = 0;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (pix_valid && pix_col == 4) break;
      end
      chk("abort_at_col4", pix_col, 4);
      reset = 1;
      @(negedge clk);
      chk("abort_busy", busy, 0);
      chk("abort_valid", pix_valid, 0);
      chk("abort_ack", ack, 0);
      reset = 0;
      t = cyc + 1;
      wait_burst(t, 2, slot(req_addr, 2));
      req = '0;
      @(negedge clk);

      // randomized traffic, including changes mid-burst and rare resets
      for (int k = 0; k < 1500; k++) begin
         if ($urandom_range(0, 3) == 0) req = N'($urandom);
         if ($urandom_range(0, 5) == 0) begin
            nb = AW'($urandom);
            set_addr($urandom_range(0, N - 1), nb);
         end
         reset = ($urandom_range(0, 299) == 0);
         @(negedge clk);
      end
      reset = 0;
      req = '0;
      for (int k = 0; k < 40 && busy; k++) @(negedge clk);
      chk("final_idle", busy, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
